// File: rtl/nes_tetris_soc_nios2_gen2_0_cpu_debug_ocimem_if.sv
`default_nettype none
// ============================================================================
// Module      : nes_tetris_soc_nios2_gen2_0_cpu_debug_ocimem_if
// Description : Avalon-MM slave bundle through which the CPU reaches the
//               debug monitor RAM.
//   avs_address     CPU word address (ADDR_W bits)
//   avs_read        read strobe
//   avs_write       write strobe
//   avs_writedata   32-bit write data
//   avs_readdata    32-bit read data, valid the cycle after acceptance
//   avs_waitrequest access stalled this cycle
// Revision    : 1.0 - initial release
// ============================================================================
interface nes_tetris_soc_nios2_gen2_0_cpu_debug_ocimem_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] avs_address;
  logic              avs_read;
  logic              avs_write;
  logic [31:0]       avs_writedata;
  logic [31:0]       avs_readdata;
  logic              avs_waitrequest;

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata,
    input  avs_readdata, avs_waitrequest
  );

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata,
    output avs_readdata, avs_waitrequest
  );
endinterface
`default_nettype wire

// File: rtl/nes_tetris_soc_nios2_gen2_0_cpu_debug_ocimem.sv
`default_nettype none
// ============================================================================
// Module      : nes_tetris_soc_nios2_gen2_0_cpu_debug_ocimem
// Description : Debug monitor memory controller. Executes JTAG address-load,
//               write and read-next commands against a private single-port
//               monitor RAM and shares that RAM with the CPU over Avalon-MM.
//   clk, reset               system clock, synchronous active-high reset
//   jdo[37:0]                JTAG data word (address in [ADDR_W+16:17],
//                            write data in [34:3])
//   take_action_ocimem_a     address load + read
//   take_action_ocimem_b     write + address increment
//   take_no_action_ocimem_a  address increment + read
//   debugack                 CPU halted; JTAG commands legal only when high
//   MonDReg                  monitor data register
//   monitor_ready            last JTAG command complete
//   monitor_error            sticky illegal-command flag
//   avs                      CPU Avalon-MM slave port (readLatency 1)
// Revision    : 1.0 - initial release
// ============================================================================
module nes_tetris_soc_nios2_gen2_0_cpu_debug_ocimem #(
  parameter int ADDR_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [37:0] jdo,
  input  logic        take_action_ocimem_a,
  input  logic        take_action_ocimem_b,
  input  logic        take_no_action_ocimem_a,
  input  logic        debugack,
  output logic [31:0] MonDReg,
  output logic        monitor_ready,
  output logic        monitor_error,
  nes_tetris_soc_nios2_gen2_0_cpu_debug_ocimem_if.slave avs
);

  localparam int              c_depth    = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] c_addr_one = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RD_ISSUE = 2'd1,
    ST_RD_CAPT  = 2'd2,
    ST_WR       = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wr_data;
  logic [31:0]       r_ram [c_depth];
  logic [31:0]       r_ram_q;

  logic              w_any_take;
  logic              w_accept;
  logic              w_illegal;
  logic              w_cmd_wr;
  logic              w_cmd_load;
  logic              w_cmd_next;

  logic              w_jtag_owns;
  logic              w_cpu_rd;
  logic              w_cpu_wr;
  logic [ADDR_W-1:0] w_ram_addr;
  logic [31:0]       w_ram_wdata;
  logic              w_ram_we;
  logic              w_ram_re;

  // jdo bits outside the address and data fields carry nothing for this block.
  logic              w_unused;
  assign w_unused = ^{jdo[37:35], jdo[2:0]};

  // --------------------------------------------------------------------------
  // Command FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_any_take   = take_action_ocimem_a | take_action_ocimem_b |
                   take_no_action_ocimem_a;
    w_accept     = w_any_take & debugack & (r_state == ST_IDLE);
    w_illegal    = w_any_take & ~w_accept;
    // Priority b > action_a > no_action_a; losers vanish without an error.
    w_cmd_wr     = w_accept & take_action_ocimem_b;
    w_cmd_load   = w_accept & ~take_action_ocimem_b & take_action_ocimem_a;
    w_cmd_next   = w_accept & ~take_action_ocimem_b & ~take_action_ocimem_a &
                   take_no_action_ocimem_a;

    case (r_state)
      ST_IDLE: begin
        if (w_cmd_wr) begin
          w_state_next = ST_WR;
        end else if (w_cmd_load || w_cmd_next) begin
          w_state_next = ST_RD_ISSUE;
        end
      end
      ST_RD_ISSUE: w_state_next = ST_RD_CAPT;
      ST_RD_CAPT:  w_state_next = ST_IDLE;
      ST_WR:       w_state_next = ST_IDLE;
      default:     w_state_next = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Address, monitor data and status registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr        <= '0;
      r_wr_data     <= '0;
      MonDReg       <= '0;
      monitor_ready <= 1'b0;
      monitor_error <= 1'b0;
    end else begin
      if (w_accept) begin
        monitor_ready <= 1'b0;
        monitor_error <= 1'b0;
      end else if (w_illegal) begin
        monitor_error <= 1'b1;
      end

      if (w_cmd_load) begin
        r_addr <= jdo[ADDR_W+16:17];
      end else if (w_cmd_next || (r_state == ST_WR)) begin
        r_addr <= r_addr + c_addr_one;
      end

      // jdo is only guaranteed during the pulse, so the write data is
      // captured here for use in the WR cycle.
      if (w_cmd_wr) begin
        r_wr_data <= jdo[34:3];
      end

      if (r_state == ST_RD_CAPT) begin
        MonDReg       <= r_ram_q;
        monitor_ready <= 1'b1;
      end

      if (r_state == ST_WR) begin
        monitor_ready <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Single-port monitor RAM shared between JTAG FSM and CPU
  // --------------------------------------------------------------------------
  assign w_jtag_owns = (r_state == ST_RD_ISSUE) || (r_state == ST_WR);
  assign w_cpu_rd    = avs.avs_read  & ~w_jtag_owns;
  assign w_cpu_wr    = avs.avs_write & ~w_jtag_owns;
  assign w_ram_addr  = w_jtag_owns ? r_addr : avs.avs_address;
  assign w_ram_wdata = (r_state == ST_WR) ? r_wr_data : avs.avs_writedata;
  assign w_ram_we    = ~reset & ((r_state == ST_WR) | w_cpu_wr);
  assign w_ram_re    = (r_state == ST_RD_ISSUE) | w_cpu_rd;

  always_ff @(posedge clk) begin
    if (w_ram_we) begin
      r_ram[w_ram_addr] <= w_ram_wdata;
    end
  end

  // One read register serves both masters. A CPU read accepted in RD_CAPT
  // overwrites it on the same edge MonDReg samples it, which is safe because
  // MonDReg takes the pre-edge value.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ram_q <= '0;
    end else if (w_ram_re) begin
      r_ram_q <= r_ram[w_ram_addr];
    end
  end

  assign avs.avs_readdata    = r_ram_q;
  assign avs.avs_waitrequest = w_jtag_owns & (avs.avs_read | avs.avs_write);

endmodule
`default_nettype wire

// File: tb/tb_nes_tetris_soc_nios2_gen2_0_cpu_debug_ocimem.sv
`default_nettype none
// ============================================================================
// Module      : tb_nes_tetris_soc_nios2_gen2_0_cpu_debug_ocimem
// Description : Self-checking bench for the debug monitor memory controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nes_tetris_soc_nios2_gen2_0_cpu_debug_ocimem;

  localparam int ADDR_W = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [37:0] jdo;
  logic        take_action_ocimem_a;
  logic        take_action_ocimem_b;
  logic        take_no_action_ocimem_a;
  logic        debugack;
  logic [31:0] MonDReg;
  logic        monitor_ready;
  logic        monitor_error;

  nes_tetris_soc_nios2_gen2_0_cpu_debug_ocimem_if #(.ADDR_W(ADDR_W)) avs_if ();

  nes_tetris_soc_nios2_gen2_0_cpu_debug_ocimem #(.ADDR_W(ADDR_W)) u_dut (
    .clk                     (clk),
    .reset                   (reset),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .debugack                (debugack),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error),
    .avs                     (avs_if)
  );

  always #5 clk = ~clk;

  typedef enum {OP_LOAD, OP_WRITE, OP_NEXT} op_e;

  typedef struct {
    op_e         op;
    logic        ack;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [31:0] exp_mon;
    logic        exp_ready;
    logic        exp_err;
    int          exp_low;   // cycles monitor_ready stays low; 0 = dropped cmd
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] mon;
    logic        ready;
    logic        err;
    int          low;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(op_e op, logic ack, logic [7:0] addr, logic [31:0] data,
                              logic [31:0] mon, logic rdy, logic err, int low);
    vec_t v;
    v.op = op; v.ack = ack; v.addr = addr; v.data = data;
    v.exp_mon = mon; v.exp_ready = rdy; v.exp_err = err; v.exp_low = low;
    return v;
  endfunction

  task automatic drive_cmd(input op_e op, input logic [7:0] addr, input logic [31:0] data);
    jdo = '0;
    if (op == OP_WRITE) jdo[34:3] = data;
    else                jdo[24:17] = addr;
    take_action_ocimem_a    = (op == OP_LOAD);
    take_action_ocimem_b    = (op == OP_WRITE);
    take_no_action_ocimem_a = (op == OP_NEXT);
  endtask

  task automatic release_cmd();
    take_action_ocimem_a    = 1'b0;
    take_action_ocimem_b    = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    jdo = {6'($urandom), $urandom};
  endtask

  task automatic do_op(input vec_t v, input string name);
    exp_t e;
    exp_t got;
    int   low;
    e.name = name; e.mon = v.exp_mon; e.ready = v.exp_ready;
    e.err = v.exp_err; e.low = v.exp_low;
    sb.push_back(e);

    debugack = v.ack;
    drive_cmd(v.op, v.addr, v.data);
    tick();
    release_cmd();
    debugack = 1'b1;

    low = 0;
    if (v.exp_low > 0) begin
      while (!monitor_ready && low < 8) begin
        low++;
        tick();
      end
    end

    got = sb.pop_front();
    if (got.low > 0) check({got.name, ".ready_low_cycles"}, low, got.low);
    check({got.name, ".MonDReg"},       MonDReg,       got.mon);
    check({got.name, ".monitor_ready"}, monitor_ready, got.ready);
    check({got.name, ".monitor_error"}, monitor_error, got.err);
  endtask

  task automatic cpu_write(input logic [7:0] a, input logic [31:0] d);
    int w;
    w = 0;
    avs_if.avs_address   = a;
    avs_if.avs_writedata = d;
    avs_if.avs_write     = 1'b1;
    #1;
    while (avs_if.avs_waitrequest && w < 4) begin
      w++;
      tick();
    end
    tick();
    avs_if.avs_write = 1'b0;
  endtask

  task automatic cpu_read(input logic [7:0] a, output logic [31:0] d, output int w);
    w = 0;
    avs_if.avs_address = a;
    avs_if.avs_read    = 1'b1;
    #1;
    while (avs_if.avs_waitrequest && w < 4) begin
      w++;
      tick();
    end
    tick();
    avs_if.avs_read = 1'b0;
    d = avs_if.avs_readdata;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[12];
    logic [31:0] d;
    int          w;

    tbl[0]  = mk(OP_LOAD,  1'b1, 8'h10, 32'h0,        32'h10101010, 1'b1, 1'b0, 2);
    tbl[1]  = mk(OP_WRITE, 1'b1, 8'h00, 32'hDEADBEEF, 32'h10101010, 1'b1, 1'b0, 1);
    tbl[2]  = mk(OP_LOAD,  1'b1, 8'h10, 32'h0,        32'hDEADBEEF, 1'b1, 1'b0, 2);
    tbl[3]  = mk(OP_NEXT,  1'b1, 8'h00, 32'h0,        32'h11111111, 1'b1, 1'b0, 2);
    tbl[4]  = mk(OP_LOAD,  1'b1, 8'hFF, 32'h0,        32'hFFFF0000, 1'b1, 1'b0, 2);
    tbl[5]  = mk(OP_WRITE, 1'b1, 8'h00, 32'h00000001, 32'hFFFF0000, 1'b1, 1'b0, 1);
    tbl[6]  = mk(OP_NEXT,  1'b1, 8'h00, 32'h0,        32'h01010101, 1'b1, 1'b0, 2);
    tbl[7]  = mk(OP_LOAD,  1'b1, 8'hFF, 32'h0,        32'h00000001, 1'b1, 1'b0, 2);
    tbl[8]  = mk(OP_WRITE, 1'b0, 8'h00, 32'h12345678, 32'h00000001, 1'b1, 1'b1, 0);
    tbl[9]  = mk(OP_NEXT,  1'b1, 8'h00, 32'h0,        32'hA5A5A5A5, 1'b1, 1'b0, 2);
    tbl[10] = mk(OP_LOAD,  1'b0, 8'h10, 32'h0,        32'hA5A5A5A5, 1'b1, 1'b1, 0);
    tbl[11] = mk(OP_LOAD,  1'b1, 8'hFF, 32'h0,        32'h00000001, 1'b1, 1'b0, 2);

    reset = 1'b1;
    debugack = 1'b1;
    jdo = '0;
    take_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    avs_if.avs_address = '0;
    avs_if.avs_read = 1'b0;
    avs_if.avs_write = 1'b0;
    avs_if.avs_writedata = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    check("reset.MonDReg",         MonDReg,                32'h0);
    check("reset.monitor_ready",   monitor_ready,          32'h0);
    check("reset.monitor_error",   monitor_error,          32'h0);
    check("reset.avs_readdata",    avs_if.avs_readdata,    32'h0);
    check("reset.avs_waitrequest", avs_if.avs_waitrequest, 32'h0);

    cpu_write(8'h00, 32'hA5A5A5A5);
    cpu_write(8'h01, 32'h01010101);
    cpu_write(8'h10, 32'h10101010);
    cpu_write(8'h11, 32'h11111111);
    cpu_write(8'h20, 32'hCAFEF00D);
    cpu_write(8'h21, 32'h21212121);
    cpu_write(8'hFF, 32'hFFFF0000);

    for (int i = 0; i < 12; i++) begin
      do_op(tbl[i], $sformatf("vec%0d", i));
    end

    // JTAG write visible to the CPU; idle CPU reads never stall.
    cpu_read(8'h10, d, w);
    check("cpu_rd10.data", d, 32'hDEADBEEF);
    check("cpu_rd10.wait", w, 0);

    // CPU read collides with a JTAG read entering RD_ISSUE.
    drive_cmd(OP_LOAD, 8'h10, 32'h0);
    tick();
    release_cmd();
    cpu_read(8'h20, d, w);
    check("contend.wait",          w,             1);
    check("contend.avs_readdata",  d,             32'hCAFEF00D);
    check("contend.MonDReg",       MonDReg,       32'hDEADBEEF);
    check("contend.monitor_ready", monitor_ready, 32'h1);

    // Command arriving while busy is dropped and flags an error.
    drive_cmd(OP_LOAD, 8'h20, 32'h0);
    tick();
    drive_cmd(OP_WRITE, 8'h00, 32'h55555555);
    tick();
    release_cmd();
    check("busy.monitor_error", monitor_error, 32'h1);
    check("busy.monitor_ready", monitor_ready, 32'h0);
    tick();
    check("busy.MonDReg",       MonDReg,       32'hCAFEF00D);
    check("busy.monitor_ready2", monitor_ready, 32'h1);
    check("busy.monitor_error2", monitor_error, 32'h1);
    // A unchanged by the dropped write: read-next yields RAM[0x21].
    do_op(mk(OP_NEXT, 1'b1, 8'h00, 32'h0, 32'h21212121, 1'b1, 1'b0, 2), "after_busy");

    // Reset asserted during RD_ISSUE.
    drive_cmd(OP_LOAD, 8'h30, 32'h0);
    tick();
    release_cmd();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midreset.MonDReg",         MonDReg,                32'h0);
    check("midreset.monitor_ready",   monitor_ready,          32'h0);
    check("midreset.monitor_error",   monitor_error,          32'h0);
    check("midreset.avs_readdata",    avs_if.avs_readdata,    32'h0);
    check("midreset.avs_waitrequest", avs_if.avs_waitrequest, 32'h0);
    do_op(mk(OP_LOAD, 1'b1, 8'h11, 32'h0, 32'h11111111, 1'b1, 1'b0, 2), "after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
